// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states,
// transaction owner id, RISC-V load/store funct3 codes and alignment check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic m;
        m = 1'b0;
        if (funct3 == F3_LW || funct3 == F3_SW)
            m = |addr;
        else if (funct3 == F3_LH || funct3 == F3_SH)
            m = addr[0];
        else if (funct3 == F3_LB || funct3 == F3_SB || funct3 == F3_LBU)
            m = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating count of arbitrations the DMA port has lost to the core;
// starve forces the next DMA request to win.
module dmem_arb_starve #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != CW'(MAX_WAIT))
            cnt <= cnt + 1'b1;
    end

    assign starve = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) arbiter in front of the single data-memory port.
// Define DMEM_ARB_STATS_EN to add saturating grant and error counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int ACC_LAT    = 1,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           c_cnt,
    output logic [15:0]           d_cnt,
    output logic [15:0]           err_cnt
`endif
);

    localparam int LW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    arb_state_t            state, nstate;
    owner_t                own;
    logic                  r_we, r_err;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_f3;
    logic [LW-1:0]         lat;

    logic                  starve, c_win, d_win, grant, g_we, g_mis, in_acc, in_resp;
    logic [DM_ADDRESS-1:0] g_addr;
    logic [DATA_W-1:0]     g_wdata;
    logic [2:0]            g_f3;

    // A starving DMA request beats the core; otherwise DMA only wins an idle core.
    assign d_win  = (state == IDLE) & d_req & (starve | ~c_req);
    assign c_win  = (state == IDLE) & c_req & ~d_win;
    assign grant  = c_win | d_win;
    assign c_gnt  = c_win;
    assign d_gnt  = d_win;

    assign g_we    = d_win ? d_we     : c_we;
    assign g_addr  = d_win ? d_addr   : c_addr;
    assign g_wdata = d_win ? d_wdata  : c_wdata;
    assign g_f3    = d_win ? d_funct3 : c_funct3;
    assign g_mis   = is_misaligned(g_f3, g_addr[1:0]);

    dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (c_win & d_req),
        .clr    (d_win),
        .starve (starve)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (grant) nstate = g_mis ? RESP : ACCESS;
            ACCESS:  if (lat == '0) nstate = RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            own     <= OWN_CORE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            lat     <= '0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= nstate;
            if (grant) begin
                own     <= d_win ? OWN_DMA : OWN_CORE;
                r_we    <= g_we;
                r_err   <= g_mis;
                r_addr  <= g_addr;
                r_wdata <= g_wdata;
                r_f3    <= g_f3;
                lat     <= LW'(ACC_LAT - 1);
                if (g_mis) begin
                    if (d_win) d_rdata <= '0;
                    else       c_rdata <= '0;
                end
            end else if (state == ACCESS) begin
                if (lat != '0)
                    lat <= lat - 1'b1;
                else if (own == OWN_DMA)
                    d_rdata <= r_we ? '0 : rd;
                else
                    c_rdata <= r_we ? '0 : rd;
            end
        end
    end

    // Memory strobes are decoded from state so reset removes them immediately.
    assign in_acc   = (state == ACCESS);
    assign in_resp  = (state == RESP);
    assign MemRead  = in_acc & ~r_we;
    assign MemWrite = in_acc & r_we;
    assign a        = in_acc ? r_addr  : '0;
    assign wd       = in_acc ? r_wdata : '0;
    assign Funct3   = in_acc ? r_f3    : '0;

    assign c_rvalid = in_resp & (own == OWN_CORE);
    assign d_rvalid = in_resp & (own == OWN_DMA);
    assign c_err    = c_rvalid & r_err;
    assign d_err    = d_rvalid & r_err;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt   <= '0;
            d_cnt   <= '0;
            err_cnt <= '0;
        end else begin
            if (c_win && c_cnt != 16'hFFFF)             c_cnt   <= c_cnt + 16'd1;
            if (d_win && d_cnt != 16'hFFFF)             d_cnt   <= d_cnt + 16'd1;
            if (in_resp && r_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
